// File: rtl/ray_march_engine.sv
// ray_march_engine: fixed-step ray marcher over a flattened occupancy grid.
// Define RAY_ABORT_EN to add the ABORT input that cancels in-flight rays.
module ray_march_engine #(
  parameter int MAP_W      = 8,
  parameter int MAP_H      = 8,
  parameter int IDX_W      = 3,
  parameter int FRAC_BITS  = 14,
  parameter int DIR_W      = 16,
  parameter int STEP_SHIFT = 4,
  parameter int MAX_STEPS  = 255,
  parameter int DIST_W     = 8
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
`ifdef RAY_ABORT_EN
  input  logic                       ABORT,
`endif
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [IDX_W+FRAC_BITS-1:0] POS_X,
  input  logic [IDX_W+FRAC_BITS-1:0] POS_Y,
  input  logic signed [DIR_W-1:0]    DIR_X,
  input  logic signed [DIR_W-1:0]    DIR_Y,
  input  logic [MAP_W*MAP_H-1:0]     MAP,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [DIST_W-1:0]          DIST,
  output logic                       HIT,
  output logic                       OOB,
  output logic                       SIDE,
  output logic [IDX_W-1:0]           HIT_COL,
  output logic [IDX_W-1:0]           HIT_ROW
);
  localparam int PW = IDX_W + FRAC_BITS + 2;
  localparam int MW = $clog2(MAP_W * MAP_H);
  localparam logic [1:0] IDLE = 2'd0, MARCH = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic armed, abort, oob, wall, side, stop;
  logic signed [DIR_W-1:0] dx, dy;
  logic signed [PW-1:0] px, py, sx, sy, cx, cy, dxe, dye;
  logic [MAP_W*MAP_H-1:0] map_q;
  logic [DIST_W-1:0] cnt, cnt1, dist_q;
  logic hit_q, oob_q, side_q;
  logic [IDX_W-1:0] col_q, row_q, col, row;
  logic [IDX_W:0] fx, fy;
  logic [MW-1:0] bit_idx;
`ifdef RAY_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif
  assign dxe = {{(PW-DIR_W){dx[DIR_W-1]}}, dx};
  assign dye = {{(PW-DIR_W){dy[DIR_W-1]}}, dy};
  assign cx = px + sx;
  assign cy = py + sy;
  assign fx = cx[PW-2:FRAC_BITS];
  assign fy = cy[PW-2:FRAC_BITS];
  assign col = cx[FRAC_BITS +: IDX_W];
  assign row = cy[FRAC_BITS +: IDX_W];
  assign bit_idx = MW'(row) * MW'(MAP_W) + MW'(col);
  assign oob = cx[PW-1] | cy[PW-1] | (fx >= (IDX_W+1)'(MAP_W)) | (fy >= (IDX_W+1)'(MAP_H));
  assign wall = !oob && map_q[bit_idx];
  // A changed x floor means the column boundary was crossed, including corners.
  assign side = px[PW-1:FRAC_BITS] == cx[PW-1:FRAC_BITS];
  assign cnt1 = cnt + 1'b1;
  assign stop = oob | wall | (cnt1 == DIST_W'(MAX_STEPS));
  assign IN_READY = RESET_N && state == IDLE;
  assign OUT_VALID = RESET_N && state == DONE;
  assign DIST = RESET_N ? dist_q : '0;
  assign HIT = RESET_N && hit_q;
  assign OOB = RESET_N && oob_q;
  assign SIDE = RESET_N && side_q;
  assign HIT_COL = RESET_N ? col_q : '0;
  assign HIT_ROW = RESET_N ? row_q : '0;
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= IDLE;
      armed <= 1'b0;
      cnt <= '0;
      dist_q <= '0;
      hit_q <= 1'b0;
      oob_q <= 1'b0;
      side_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
    end else if (state == IDLE && IN_VALID) begin
      px <= PW'(POS_X);
      py <= PW'(POS_Y);
      dx <= DIR_X;
      dy <= DIR_Y;
      map_q <= MAP;
      cnt <= '0;
      armed <= 1'b0;
      state <= MARCH;
    end else if (state == MARCH && !armed) begin
      // Setup cycle registers the per-axis step so the adder path stays short.
      sx <= dxe >>> STEP_SHIFT;
      sy <= dye >>> STEP_SHIFT;
      armed <= 1'b1;
    end else if (state == MARCH && stop) begin
      state <= DONE;
      dist_q <= cnt1;
      hit_q <= oob | wall;
      oob_q <= oob;
      side_q <= (oob | wall) & side;
      col_q <= wall ? col : '0;
      row_q <= wall ? row : '0;
    end else if (state == MARCH) begin
      px <= cx;
      py <= cy;
      cnt <= cnt1;
    end else if (state == DONE && OUT_READY) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_ray_march_engine.sv
// tb_ray_march_engine: directed checks of latency, hit reporting, backpressure and reset.
module tb_ray_march_engine;
  logic CLK = 1'b0, RESET_N = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic [16:0] POS_X = '0, POS_Y = '0;
  logic signed [15:0] DIR_X = '0, DIR_Y = '0;
  logic [63:0] MAP = '0;
  logic IN_READY, OUT_VALID, HIT, OOB, SIDE;
  logic [7:0] DIST;
  logic [2:0] HIT_COL, HIT_ROW;
`ifdef RAY_ABORT_EN
  logic ABORT = 1'b0;
`endif
  int checks = 0, failures = 0;
  localparam logic [63:0] BORDER = 64'hFF81_8181_8181_81FF;
  ray_march_engine dut (
    .CLK(CLK), .RESET_N(RESET_N),
`ifdef RAY_ABORT_EN
    .ABORT(ABORT),
`endif
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .POS_X(POS_X), .POS_Y(POS_Y),
    .DIR_X(DIR_X), .DIR_Y(DIR_Y), .MAP(MAP), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .DIST(DIST), .HIT(HIT), .OOB(OOB), .SIDE(SIDE), .HIT_COL(HIT_COL), .HIT_ROW(HIT_ROW)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [63:0] m, input logic signed [15:0] dx, input logic signed [15:0] dy);
    @(negedge CLK);
    chk("ready_before_accept", IN_READY, 1);
    MAP = m; POS_X = 17'd57344; POS_Y = 17'd57344; DIR_X = dx; DIR_Y = dy;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    MAP = ~m;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (!OUT_VALID && n < 400) begin
      @(posedge CLK);
      #1 n++;
    end
  endtask
  task automatic consume();
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1 OUT_READY = 1'b0;
    chk("ready_after_handshake", IN_READY, 1);
    chk("valid_after_handshake", OUT_VALID, 0);
  endtask
  task automatic ray(input string tag, input logic [63:0] m, input logic signed [15:0] dx,
                     input logic signed [15:0] dy, input int lat, input int d, input int h,
                     input int o, input int s, input int c, input int r);
    int n;
    launch(m, dx, dy);
    wait_out(n);
    $display("ray %s latency=%0d", tag, n);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_dist"}, DIST, d);
    chk({tag, "_hit"}, HIT, h);
    chk({tag, "_oob"}, OOB, o);
    chk({tag, "_side"}, SIDE, s);
    chk({tag, "_col"}, HIT_COL, c);
    chk({tag, "_row"}, HIT_ROW, r);
    consume();
  endtask
  initial begin
    int n;
    logic seen;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_in_ready", IN_READY, 0);
    chk("reset_out_valid", OUT_VALID, 0);
    chk("reset_dist", DIST, 0);
    chk("reset_hit", HIT, 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("idle_in_ready", IN_READY, 1);
    ray("east_wall", BORDER, 16'sd16384, 16'sd0, 57, 56, 1, 0, 0, 7, 3);
    ray("north_wall", BORDER, 16'sd0, -16'sd16384, 42, 41, 1, 0, 1, 3, 0);
    ray("east_oob", 64'd0, 16'sd16384, 16'sd0, 73, 72, 1, 1, 0, 0, 0);
    ray("zero_dir", BORDER, 16'sd0, 16'sd0, 256, 255, 0, 0, 0, 0, 0);
    launch(BORDER, 16'sd16384, 16'sd0);
    wait_out(n);
    chk("bp_latency", n, 57);
    POS_X = 17'd57344; POS_Y = 17'd57344; DIR_X = 16'sd0; DIR_Y = -16'sd16384; MAP = BORDER;
    IN_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("bp_valid", OUT_VALID, 1);
      chk("bp_in_ready", IN_READY, 0);
      chk("bp_dist", DIST, 56);
      chk("bp_col", HIT_COL, 7);
    end
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1 OUT_READY = 1'b0;
    chk("bp_ready_rise", IN_READY, 1);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    chk("bp_accepted", IN_READY, 0);
    wait_out(n);
    chk("bp_second_latency", n, 42);
    chk("bp_second_dist", DIST, 41);
    chk("bp_second_row", HIT_ROW, 0);
    consume();
    launch(BORDER, 16'sd16384, 16'sd0);
    repeat (19) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_in_ready", IN_READY, 0);
    chk("rst_mid_valid", OUT_VALID, 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("rst_release_ready", IN_READY, 1);
    seen = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      seen |= OUT_VALID;
    end
    chk("rst_no_result", seen, 0);
`ifdef RAY_ABORT_EN
    launch(BORDER, 16'sd16384, 16'sd0);
    repeat (19) @(posedge CLK);
    @(negedge CLK);
    ABORT = 1'b1;
    @(posedge CLK);
    #1 ABORT = 1'b0;
    chk("abort_ready", IN_READY, 1);
    seen = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      seen |= OUT_VALID;
    end
    chk("abort_no_result", seen, 0);
    ray("after_abort", BORDER, 16'sd16384, 16'sd0, 57, 56, 1, 0, 0, 7, 3);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
